// File: rtl/alu_pkg.sv
// Shared opcode/state encodings, flag bundle and latency constants for seq_alu.
// Latency: n/a (types and constants only). Backpressure: n/a.
// Optional multiplier is selected with SEQ_ALU_MUL_EN; the encodings here are build-independent.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic carryout;
        logic overflow;
        logic parity;
        logic zero;
    } flags_t;

    // Accept-edge to out_valid distance, in rising edges.
    localparam int LAT_SINGLE_CYCLE = 1;

    function automatic int op_latency(op_e op, int width, bit mul_en);
        return (op == OP_MUL && mul_en) ? width + 1 : LAT_SINGLE_CYCLE;
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Operation request / result response bundle for seq_alu.
// Latency: n/a (wires only). Backpressure: valid/ready on both request and response sides.
// Shape is identical with and without SEQ_ALU_MUL_EN.
interface seq_alu_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       s;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carryout;
    logic             overflow;
    logic             parity;
    logic             zero;

    modport master (
        output in_valid, a, b, s, out_ready,
        input  in_ready, out_valid, result, carryout, overflow, parity, zero
    );

    modport slave (
        input  in_valid, a, b, s, out_ready,
        output in_ready, out_valid, result, carryout, overflow, parity, zero
    );
endinterface

// File: rtl/alu_shift_add_mul.sv
// Iterative shift-add multiplier producing the full 2*WIDTH-bit product; only built with SEQ_ALU_MUL_EN.
// Latency: start edge loads operands, WIDTH further edges iterate, done is high after the last one.
// Backpressure: none; done stays high until the next edge, the owner must sample it then.
module alu_shift_add_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               run_q, run_d;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        if (start) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            cnt_d    = CW'(WIDTH);
            run_d    = 1'b1;
        end else if (run_q) begin
            if (cnt_q != '0) begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
            end else begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
        end
    end

    // Counter reaching zero while running means the last partial product has been added.
    assign done    = run_q && (cnt_q == '0);
    assign product = acc_q;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with registered result/flags; SEQ_ALU_MUL_EN adds a WIDTH-cycle shift-add MUL.
// Latency: 1 edge accept->out_valid for most opcodes, WIDTH+1 for MUL when enabled.
// Backpressure: one op in flight; in_ready only in IDLE, result held in DONE until out_ready.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic   clk,
    input  logic   rst_n,
    seq_alu_if.slave bus
);
    state_e             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    flags_t             flags_q, flags_d;

    op_e                op;
    logic               accept;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_cout;
    logic               alu_ovf;
    logic [WIDTH:0]     sum_ext;
    logic [WIDTH:0]     diff_ext;

    assign op     = op_e'(bus.s);
    assign accept = bus.in_valid && (state_q == ST_IDLE);

    function automatic flags_t mk_flags(logic [WIDTH-1:0] r, logic c, logic o);
        flags_t f;
        f.carryout = c;
        f.overflow = o;
        f.parity   = ^r;
        f.zero     = ~|r;
        return f;
    endfunction

`ifdef SEQ_ALU_MUL_EN
    logic                 mul_start;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   mul_product;

    assign mul_start = accept && (op == OP_MUL);

    alu_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (bus.a),
        .b       (bus.b),
        .done    (mul_done),
        .product (mul_product)
    );
`endif

    // Single-cycle datapath; MUL yields zero here and is overridden by the multiplier when built.
    always_comb begin
        sum_ext  = {1'b0, bus.a} + {1'b0, bus.b};
        diff_ext = {1'b0, bus.a} - {1'b0, bus.b};
        alu_res  = '0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res  = sum_ext[WIDTH-1:0];
                alu_cout = sum_ext[WIDTH];
                alu_ovf  = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                           (sum_ext[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res  = diff_ext[WIDTH-1:0];
                alu_cout = diff_ext[WIDTH];
                alu_ovf  = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                           (diff_ext[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND: alu_res = bus.a & bus.b;
            OP_OR:  alu_res = bus.a | bus.b;
            OP_XOR: alu_res = bus.a ^ bus.b;
            OP_SHL: begin
                alu_res  = {bus.a[WIDTH-2:0], 1'b0};
                alu_cout = bus.a[WIDTH-1];
            end
            OP_SHR: begin
                alu_res  = {1'b0, bus.a[WIDTH-1:1]};
                alu_cout = bus.a[0];
            end
            default: begin
                alu_res  = '0;
                alu_cout = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
`ifdef SEQ_ALU_MUL_EN
                    if (op == OP_MUL) begin
                        state_d = ST_BUSY;
                    end else
`endif
                    begin
                        state_d  = ST_DONE;
                        result_d = alu_res;
                        flags_d  = mk_flags(alu_res, alu_cout, alu_ovf);
                    end
                end
            end
`ifdef SEQ_ALU_MUL_EN
            ST_BUSY: begin
                if (mul_done) begin
                    state_d  = ST_DONE;
                    result_d = mul_product[WIDTH-1:0];
                    flags_d  = mk_flags(mul_product[WIDTH-1:0],
                                        |mul_product[2*WIDTH-1:WIDTH], 1'b0);
                end
            end
`endif
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.result    = result_q;
    assign bus.carryout  = flags_q.carryout;
    assign bus.overflow  = flags_q.overflow;
    assign bus.parity    = flags_q.parity;
    assign bus.zero      = flags_q.zero;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=4; expectations come from an integer reference model via a queue.
// Works in both builds: SEQ_ALU_MUL_EN selects the expected MUL behaviour.
module tb_seq_alu;
    localparam int W = 4;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         o;
        logic         p;
        logic         z;
        int           lat;
    } exp_t;

    exp_t sb[$];

    seq_alu_if #(.WIDTH(W)) bus ();

    seq_alu #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int a, input int b, input int s);
        exp_t e;
        int   r, sa, sb_, sr;
        sa  = (a >= 8) ? a - 16 : a;
        sb_ = (b >= 8) ? b - 16 : b;
        e.c = 1'b0;
        e.o = 1'b0;
        e.lat = 1;
        r = 0;
        case (s)
            0: begin r = a + b; e.c = (r > 15); sr = sa + sb_; e.o = (sr > 7 || sr < -8); end
            1: begin r = a - b; e.c = (a < b);  sr = sa - sb_; e.o = (sr > 7 || sr < -8); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin r = a * 2; e.c = (a >= 8); end
            6: begin r = a / 2; e.c = (a % 2 == 1); end
            default: begin
`ifdef SEQ_ALU_MUL_EN
                r = a * b; e.c = (r > 15); e.lat = W + 1;
`else
                r = 0;
`endif
            end
        endcase
        r = r & 15;
        e.res = r[W-1:0];
        e.z = (r == 0);
        e.p = ($countones(r) % 2) == 1;
        return e;
    endfunction

    // Issue one op, wait for its result, compare, optionally stall the consumer, then consume.
    task automatic do_op(input string tag, input int a, input int b, input int s, input int hold);
        exp_t e;
        int   lat;
        chk({tag, ".in_ready_pre"}, 32'(bus.in_ready), 32'd1);
        bus.a = 4'(a); bus.b = 4'(b); bus.s = 3'(s);
        bus.in_valid = 1'b1;
        sb.push_back(model(a, b, s));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 50) begin
            chk({tag, ".in_ready_busy"}, 32'(bus.in_ready), 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        e = sb.pop_front();
        chk({tag, ".latency"},  32'(lat),          32'(e.lat));
        chk({tag, ".result"},   32'(bus.result),   32'(e.res));
        chk({tag, ".carryout"}, 32'(bus.carryout), 32'(e.c));
        chk({tag, ".overflow"}, 32'(bus.overflow), 32'(e.o));
        chk({tag, ".parity"},   32'(bus.parity),   32'(e.p));
        chk({tag, ".zero"},     32'(bus.zero),     32'(e.z));
        for (int i = 0; i < hold; i++) begin
            bus.a = 4'(a ^ 15); bus.b = 4'(b ^ 5); bus.s = 3'd0;
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
            chk({tag, ".hold_valid"},  32'(bus.out_valid), 32'd1);
            chk({tag, ".hold_ready"},  32'(bus.in_ready),  32'd0);
            chk({tag, ".hold_result"}, 32'({bus.result, bus.carryout, bus.overflow, bus.parity, bus.zero}),
                32'({e.res, e.c, e.o, e.p, e.z}));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({tag, ".in_ready_post"},  32'(bus.in_ready),  32'd1);
        chk({tag, ".out_valid_post"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        int seen_valid;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.s         = '0;
        #12;
        chk("reset.result",    32'(bus.result),    32'd0);
        chk("reset.flags",     32'({bus.carryout, bus.overflow, bus.parity, bus.zero}), 32'd0);
        chk("reset.out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset.in_ready",  32'(bus.in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset.in_ready", 32'(bus.in_ready), 32'd1);

        do_op("add_4_7",  4'b0100, 4'b0111, 0, 0);
        do_op("sub_4_7",  4'b0100, 4'b0111, 1, 0);
        do_op("xor_5_5",  4'b0101, 4'b0101, 4, 0);
        do_op("and_c_a",  4'b1100, 4'b1010, 2, 0);
        do_op("or_3_8",   4'b0011, 4'b1000, 3, 0);
        do_op("shl_9",    4'b1001, 4'b0000, 5, 0);
        do_op("shr_9",    4'b1001, 4'b0000, 6, 0);
        do_op("mul_4_7",  4'b0100, 4'b0111, 7, 0);
        do_op("mul_f_f",  4'b1111, 4'b1111, 7, 0);
        do_op("add_f_1",  4'b1111, 4'b0001, 0, 0);
        do_op("sub_8_1",  4'b1000, 4'b0001, 1, 0);
        do_op("hold_add", 4'b0100, 4'b0111, 0, 3);

        // Reset in the second cycle after accept: in-flight work must vanish.
        bus.a = 4'b0100; bus.b = 4'b0111;
`ifdef SEQ_ALU_MUL_EN
        bus.s = 3'd7;
`else
        bus.s = 3'd0;
`endif
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid.result",    32'(bus.result),    32'd0);
        chk("rst_mid.flags",     32'({bus.carryout, bus.overflow, bus.parity, bus.zero}), 32'd0);
        chk("rst_mid.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_mid.in_ready",  32'(bus.in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid.in_ready_after", 32'(bus.in_ready), 32'd1);
        seen_valid = 0;
        for (int i = 0; i < W + 3; i++) begin
            if (bus.out_valid) seen_valid++;
            @(posedge clk); #1;
        end
        chk("rst_mid.no_stale_valid", 32'(seen_valid), 32'd0);

        do_op("after_rst", 4'b1001, 4'b0011, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits, legal range 2..32.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, operand/opcode presented.
REQ-005 SHALL have port in_ready, output, 1, block can accept an operation.
REQ-006 SHALL have ports a and b, input, WIDTH each, unsigned operands, two's-complement for overflow.
REQ-007 SHALL have port s, input, 3, opcode.
REQ-008 SHALL have port out_valid, output, 1, result and flags valid.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-010 SHALL have port result, output, WIDTH, registered result.
REQ-011 SHALL have ports carryout, overflow, parity, zero, output, 1 each, registered flags.

Function
REQ-012 SHALL decode s as: 000 ADD, 001 SUB (a-b), 010 AND, 011 OR, 100 XOR, 101 SHL a by 1, 110 SHR a by 1 (logical), 111 MUL (low WIDTH bits of a*b).
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-014 SHALL accept an operation on a rising edge where in_valid && in_ready, latching a, b and s.
REQ-015 SHALL, for opcodes 000-110, go IDLE->DONE on the accept edge with result/flags registered, so out_valid is high one cycle after acceptance.
REQ-016 SHALL, for MUL, go IDLE->BUSY on the accept edge, run a shift-add iteration for exactly WIDTH cycles, then enter DONE; out_valid rises WIDTH+1 edges after the accept edge.
REQ-017 SHALL hold result and all flags stable while in DONE with out_ready low; leave DONE for IDLE on the edge where out_ready is high.
REQ-018 SHALL ignore in_valid, a, b and s while in BUSY or DONE.
REQ-019 carryout SHALL be: ADD carry out of bit WIDTH-1; SUB borrow (1 when a<b unsigned); SHL bit a[WIDTH-1]; SHR bit a[0]; MUL 1 when any of product bits [2*WIDTH-1:WIDTH] is nonzero; logic ops 0.
REQ-020 overflow SHALL be signed two's-complement overflow for ADD and SUB, 0 for all other opcodes.
REQ-021 zero SHALL be 1 exactly when result is all zeros; parity SHALL be the XOR of all result bits.

Reset
REQ-022 SHALL, on rst_n low, immediately and asynchronously force state IDLE, result 0, carryout 0, overflow 0, parity 0, zero 0, and clear the multiply counter and accumulator.
REQ-023 SHALL abandon any in-progress MUL or unconsumed result on reset, with no output produced for it after rst_n deasserts.
REQ-024 SHALL allow in_ready high in the first cycle after rst_n deassertion.

Configuration
REQ-025 Macro SEQ_ALU_MUL_EN SHALL, when defined, compile in the BUSY state and multiplier per REQ-016/REQ-019.
REQ-026 Without SEQ_ALU_MUL_EN, opcode 111 SHALL complete in one cycle like REQ-015 with result 0, zero 1, parity 0, carryout 0, overflow 0; BUSY is unreachable.

Structure
REQ-027 Shared package alu_pkg SHALL hold the opcode enum (3-bit), the FSM state enum and the opcode-to-latency constants.
REQ-028 Multiplier SHALL be a sub-module alu_shift_add_mul (start, done, WIDTH-cycle shift-add, 2*WIDTH product), instantiated only under SEQ_ALU_MUL_EN.

Verification (WIDTH=4, SEQ_ALU_MUL_EN defined unless noted)
REQ-029 a=0100, b=0111, s=000 -> result 1011, carryout 0, overflow 1, parity 1, zero 0, out_valid one cycle after accept.
REQ-030 a=0100, b=0111, s=001 -> result 1101, carryout 1, overflow 0, parity 1; a=b=0101, s=100 -> result 0000, zero 1.
REQ-031 a=0100, b=0111, s=111 -> in_ready low 5 cycles, out_valid 5 edges after accept, result 1100, carryout 1; without macro -> result 0000, zero 1, latency 1.
REQ-032 a=1001, s=101 -> result 0010, carryout 1; a=1001, s=110 -> result 0100, carryout 1.
REQ-033 Hold out_ready low 3 cycles after out_valid -> result/flags unchanged, in_ready low, new in_valid ignored; out_ready high -> IDLE next edge.
REQ-034 Assert rst_n low during MUL cycle 2 -> outputs zero immediately, in_ready high after release, no stale out_valid.
